shifter_pipe: RTL

//   Parametrised, pipelined barrel shifter. Successor to the single-cycle 32-bit shifter.

---
 rtl/shifter_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined SLL/SRL/SRA barrel shifter; SHIFTER_PIPE_ROTATE_EN turns op 11 into ROR (else SRL).
// Latency: STAGES cycles accept-to-out_valid, one operation per cycle.
// Backpressure: combinational ready chain from out_ready; empty stages load even while downstream stalls.
module shifter_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_data,
    input  logic [$clog2(XLEN)-1:0] in_shamt,
    input  logic [1:0]              in_op,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_data,
    output logic [TAG_W-1:0]        out_tag
);
    localparam int LVLS = $clog2(XLEN);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [XLEN-1:0] ONES = '1;
`ifdef SHIFTER_PIPE_ROTATE_EN
    localparam logic [1:0] OP_ROR = 2'b11;
`endif

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] rdy;
    logic [XLEN-1:0]   dat_q [STAGES];
    logic [LVLS-1:0]   sh_q  [STAGES];
    logic [1:0]        op_q  [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [XLEN-1:0]   dat_d [STAGES];

    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        for (int b = 0; b < XLEN; b++) r[b] = d[XLEN-1-b];
        return r;
    endfunction

    // One right-shift level by n; SLL arrives here already bit-reversed.
    function automatic logic [XLEN-1:0] shift_lvl(input logic [XLEN-1:0] d, input int n,
                                                  input logic [1:0] op);
        logic [XLEN-1:0] r;
        r = d >> n;
`ifdef SHIFTER_PIPE_ROTATE_EN
        if (op == OP_ROR)
            r = r | (d << (XLEN - n));
        else if (op == OP_SRA && d[XLEN-1])
            r = r | ~(ONES >> n);
`else
        if (op == OP_SRA && d[XLEN-1])
            r = r | ~(ONES >> n);
`endif
        return r;
    endfunction

    // Unrolled chain: a stage is ready unless it and everything below it is full and out stalls.
    always_comb begin
        rdy = '0;
        for (int k = 0; k < STAGES; k++) begin
            logic full;
            full = 1'b1;
            for (int j = k; j < STAGES; j++) full = full & v_q[j];
            rdy[k] = out_ready | ~full;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [XLEN-1:0] src;
        logic [XLEN-1:0] cur;
        logic [LVLS-1:0] sh;
        logic [1:0]      op;

        if (k == 0) begin : g_first
            assign src = (in_op == OP_SLL) ? bit_rev(in_data) : in_data;
            assign sh  = in_shamt;
            assign op  = in_op;
        end else begin : g_rest
            assign src = dat_q[k-1];
            assign sh  = sh_q[k-1];
            assign op  = op_q[k-1];
        end

        always_comb begin
            cur = src;
            for (int i = 0; i < LVLS; i++)
                if ((i * STAGES) / LVLS == k && sh[i]) cur = shift_lvl(cur, 1 << i, op);
            if (k == STAGES - 1 && op == OP_SLL) cur = bit_rev(cur);
        end

        assign dat_d[k] = cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dat_q[k] <= '0;
                sh_q[k]  <= '0;
                op_q[k]  <= '0;
                tag_q[k] <= '0;
            end
        end else if (flush) begin
            v_q <= '0;
        end else begin
            if (rdy[0]) begin
                v_q[0]   <= in_valid;
                dat_q[0] <= dat_d[0];
                sh_q[0]  <= in_shamt;
                op_q[0]  <= in_op;
                tag_q[0] <= in_tag;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k]   <= v_q[k-1];
                    dat_q[k] <= dat_d[k];
                    sh_q[k]  <= sh_q[k-1];
                    op_q[k]  <= op_q[k-1];
                    tag_q[k] <= tag_q[k-1];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign out_data  = dat_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
endmodule
